// File: rtl/spram_pkg.sv
// Shared definitions for the SPRAM loader/reader pair: SPRAM geometry, the
// reader FSM state encoding and the byte-lane mapping of a 16-bit SPRAM word.
package spram_pkg;

  localparam int          SPRAM_WORDS = 16384;
  localparam logic [15:0] FILL_BYTES  = 16'h2000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WT   = 3'd2,
    EMIT = 3'd3,
    FIN  = 3'd4
  } state_t;

  typedef enum logic {
    LANE_LO = 1'b0,
    LANE_HI = 1'b1
  } lane_t;

  // Even byte addresses live in the low half of a word, odd ones in the high half.
  function automatic lane_t byte_lane(input logic addr0);
    if (addr0) begin
      return LANE_HI;
    end else begin
      return LANE_LO;
    end
  endfunction

  // Extract the byte held in the given lane of an SPRAM word.
  function automatic logic [7:0] lane_byte(input logic [15:0] word, input lane_t lane);
    case (lane)
      LANE_HI: return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spram_stream_reader.sv
// Byte-granular streaming reader for one SB_SPRAM256KA.
// Fetches 16-bit words (RD -> WT -> EMIT) and streams the requested bytes out
// on a valid/ready interface. Each word read serves up to two bytes.
// Optional: define SPRAM_STREAM_READER_CSUM_EN to add a modulo-256 byte sum
// output (csum) for the current transfer.
module spram_stream_reader
  import spram_pkg::*;
#(
  parameter int BYTE_AW = 13,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [BYTE_AW-1:0] req_offset,
  input  logic [LEN_W-1:0]   req_len,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               done,
  output logic               busy,
`ifdef SPRAM_STREAM_READER_CSUM_EN
  output logic [7:0]         csum,
`endif
  output logic [13:0]        ram_address,
  output logic               ram_chipselect,
  input  logic [15:0]        ram_dataout
);

  state_t             state_r;
  state_t             state_next_s;
  logic [BYTE_AW-1:0] ptr_r;
  logic [LEN_W-1:0]   rem_r;
  logic [15:0]        word_r;
  logic               accept_s;
  logic               xfer_s;

  // All outputs decode registered state; req_ready is also held low while in reset.
  assign req_ready      = (state_r == IDLE) & ~rst;
  assign accept_s       = req_valid & req_ready;
  assign out_valid      = (state_r == EMIT);
  assign xfer_s         = out_valid & out_ready;
  assign out_last       = out_valid & (rem_r == LEN_W'(1'b1));
  assign out_data       = out_valid ? lane_byte(word_r, byte_lane(ptr_r[0])) : 8'h00;
  assign done           = (state_r == FIN);
  assign busy           = (state_r == RD) | (state_r == WT) | (state_r == EMIT);
  assign ram_chipselect = (state_r == RD);
  assign ram_address    = ram_chipselect ? {{(15-BYTE_AW){1'b0}}, ptr_r[BYTE_AW-1:1]} : 14'h0000;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: a word is re-read only after its odd (high) byte is consumed.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (req_len == {LEN_W{1'b0}}) begin
            state_next_s = FIN;
          end else begin
            state_next_s = RD;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      RD:   state_next_s = WT;
      WT:   state_next_s = EMIT;
      EMIT: begin
        if (xfer_s) begin
          if (rem_r == LEN_W'(1'b1)) begin
            state_next_s = FIN;
          end else if (ptr_r[0]) begin
            state_next_s = RD;
          end else begin
            state_next_s = EMIT;
          end
        end else begin
          state_next_s = EMIT;
        end
      end
      FIN:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Byte pointer and remaining count: loaded on accept, stepped on each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {BYTE_AW{1'b0}};
      rem_r <= {LEN_W{1'b0}};
    end else if (accept_s) begin
      ptr_r <= req_offset;
      rem_r <= req_len;
    end else if (xfer_s) begin
      ptr_r <= ptr_r + BYTE_AW'(1'b1);
      rem_r <= rem_r - LEN_W'(1'b1);
    end else begin
      ptr_r <= ptr_r;
      rem_r <= rem_r;
    end
  end

  // Word register: SPRAM output is valid the cycle after RD, captured in WT.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_r <= 16'h0000;
    end else if (state_r == WT) begin
      word_r <= ram_dataout;
    end else begin
      word_r <= word_r;
    end
  end

`ifdef SPRAM_STREAM_READER_CSUM_EN
  logic [7:0] csum_r;

  // Running modulo-256 sum of handshaked bytes; cleared when a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_r <= 8'h00;
    end else if (accept_s) begin
      csum_r <= 8'h00;
    end else if (xfer_s) begin
      csum_r <= csum_r + out_data;
    end else begin
      csum_r <= csum_r;
    end
  end

  assign csum = csum_r;
`endif

endmodule

// File: doc/spram_stream_reader.md
Name: spram_stream_reader

Overview:
- Read-side counterpart of the SPRAM fread loader.
- Accepts a byte-granular read request (offset, length) and fetches 16-bit words from one SB_SPRAM256KA.
- Streams the requested bytes out on a valid/ready byte interface toward the SPI/ESP response path, e.g. for dumping or write-back.
- Drives the SPRAM read port directly; the owning top muxes it against the loader/host port.

Parameters:
- BYTE_AW, 13, byte address width; addressable window is 2**BYTE_AW bytes (8 KiB, matching the loader fill size).
- LEN_W, 16, request length width in bytes.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  read request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_offset  in  BYTE_AW  start byte address.
- req_len  in  LEN_W  number of bytes to stream.
- out_data  out  8  streamed byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts byte.
- out_last  out  1  qualifies the final byte of the transfer.
- done  out  1  one-cycle pulse when the transfer completes.
- busy  out  1  high from request accept until done.
- ram_address  out  14  SPRAM word address.
- ram_chipselect  out  1  SPRAM CS. WREN is tied 0 by the owner; this block never writes.
- ram_dataout  in  16  SPRAM DATAOUT, registered, valid the cycle after address/CS.

Behaviour:
- Reset values: req_ready=0, out_valid=0, out_last=0, done=0, busy=0, ram_chipselect=0, ram_address=0, out_data=0. Reset mid-transfer abandons it: no done pulse, no further bytes.
- Byte mapping: word address = {0, byte_addr[BYTE_AW-1:1]}. Even byte = ram_dataout[7:0]; odd byte = ram_dataout[15:8]. Identical to the loader's mask mapping.
- States:
  - IDLE: req_ready=1. On accept, latch offset into the byte pointer and len into the remaining count, set busy. len==0 goes to FIN; otherwise go to RD.
  - RD: ram_chipselect=1, ram_address=pointer word. Next state WT.
  - WT: capture ram_dataout into the word register. Next state EMIT.
  - EMIT: out_valid=1, out_data = selected byte of the word register per pointer[0]. out_data/out_last are held stable while out_valid & !out_ready.
    - On handshake: pointer+=1 (wraps modulo 2**BYTE_AW), remaining-=1.
    - If remaining becomes 0: go to FIN.
    - Else if the old pointer[0]==1 (word exhausted): go to RD.
    - Else stay in EMIT for the high byte, with no re-read.
  - FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- out_last = out_valid & (remaining==1).
- Timing:
  - Accept in cycle T gives first out_valid in T+3.
  - Steady state is 2 bytes per 4 cycles with out_ready held high (RD, WT, EMIT, EMIT).
  - done is asserted in the cycle after the last handshake.
- Odd offset: the first word emits only its high byte.
- Ending on an even address: the final word emits only its low byte.
- Requests longer than the window wrap around the address space. Bytes are re-read, never an error.
- req_valid while busy is ignored (req_ready=0). The requester holds it until IDLE.
- Only the RD state asserts ram_chipselect.

Optional Feature:
- Macro: SPRAM_STREAM_READER_CSUM_EN.
- Defined: adds output port csum [7:0]. csum holds the modulo-256 sum of all bytes handshaked in the current transfer. It is cleared to 0 on request accept and is final when done pulses; it holds that value until the next accept. Reset value is 0. For len==0, csum=0.
- Undefined: no port and no adder; all other behaviour is identical.

Decomposition:
- Shared package (spram_pkg):
  - SPRAM_WORDS=16384.
  - FILL_BYTES=16'h2000 (shared with the loader).
  - State encoding localparams IDLE/RD/WT/EMIT/FIN.
  - Byte-lane select helper function (addr[0] -> lane).
- Single module; no sub-module needed. The SPRAM primitive and port mux stay in the owning top.

Test Plan:
- Preload words 0x0000=0xBBAA, 0x0001=0xDDCC. Request offset 0, len 4, out_ready=1 -> bytes AA,BB,CC,DD; out_valid first high 3 cycles after accept; out_last on DD; done one cycle later.
- Same preload, offset 1, len 2 -> bytes BB,CC; exactly 2 RD cycles (words 0 and 1).
- offset 0x1FFF, len 2, word 0x0FFF=0x11EE, word 0=0xBBAA -> bytes 11,AA (wrap); no error.
- len 0 -> done one cycle after accept, out_valid never high.
- Backpressure: out_ready toggled 1,0,0,1 -> out_data/out_last stable during stalls; no byte lost or duplicated; RD issued once per word.
- rst asserted during EMIT of a len-8 transfer -> next cycle out_valid=0, busy=0, req_ready=1, no done. With CSUM_EN, a 4-byte AA,BB,CC,DD transfer -> csum=0x0E.
